mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 8: address width in bits; legal range 8-32.
REQ-002 Parameter DATA_W, default 32: data width in bits; legal values 32 or 64.
REQ-003 Parameter TIMEOUT, default 16: maximum number of WAIT cycles before a fault; legal range 2-255.
REQ-004 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 Port clr, input, 1: asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1: control unit presents a request.
REQ-007 Port req_ready, output, 1: unit can accept a request.
REQ-008 Port req_write, input, 1: 1 = store, 0 = load.
REQ-009 Port req_dt, input, 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-010 Port req_signed, input, 1: sign-extend load data (1) or zero-extend it (0).
REQ-011 Port req_addr, input, ADDR_W: byte address.
REQ-012 Port req_wdata, input, DATA_W: store data, right-justified.
REQ-013 Port mem_mov, output, 1: memory operation valid strobe to RAM.
REQ-014 Port mem_rw, output, 1: 1 = read, 0 = write.
REQ-015 Port mem_dt, output, 2: latched access size to RAM.
REQ-016 Port mem_addr, output, ADDR_W: latched address (MAR).
REQ-017 Port mem_wdata, output, DATA_W: latched, masked store data (MDR).
REQ-018 Port mem_rdata, input, DATA_W: RAM read data, right-justified.
REQ-019 Port mem_moc, input, 1: RAM memory-operation-complete.
REQ-020 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-021 Port rsp_rdata, output, DATA_W: extended load data; 0 for stores and faults.
REQ-022 Port rsp_fault, output, 1: qualifies rsp_valid; indicates a misaligned, reserved-size or timed-out access.
REQ-023 Port busy, output, 1: state is not IDLE.

Function
REQ-024 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-025 req_ready SHALL be high only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-026 On acceptance, the unit SHALL latch addr, dt, write and signed, plus req_wdata masked to the access size (upper bits zero), and go to ISSUE.
REQ-027 A misaligned or reserved-size request SHALL go directly to RESP with a fault and no mem_mov.
- Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- Reserved: req_dt = 11.
REQ-028 ISSUE SHALL drive mem_mov = 1 and mem_rw = ~write for exactly one cycle, then go to WAIT.
REQ-029 In WAIT, mem_mov SHALL remain 1; mem_moc is sampled only in WAIT, and mem_moc during ISSUE is ignored.
REQ-030 When mem_moc = 1 in WAIT, the unit SHALL capture the load data, deassert mem_mov on the next cycle and go to RESP.
REQ-031 RESP SHALL last exactly one cycle with rsp_valid = 1, then return to IDLE; there is no back-pressure on responses.
REQ-032 Load extension SHALL work as follows:
- byte: mem_rdata[7:0] extended to DATA_W;
- halfword: mem_rdata[15:0] extended to DATA_W;
- word: mem_rdata[31:0] extended when DATA_W = 64.
REQ-033 rsp_rdata SHALL hold its value until the next RESP.
REQ-034 Minimum request-to-response latency SHALL be 3 cycles (ISSUE, one WAIT cycle, RESP); a fault detected at acceptance SHALL respond 1 cycle after acceptance.
REQ-035 A request presented in a non-IDLE state SHALL be neither accepted nor lost; it is held by the requester until req_ready is high.

Reset
REQ-036 While clr = 0, the unit SHALL force the following regardless of clk, aborting any access in flight:
- state = IDLE;
- mem_mov = 0, mem_rw = 1, mem_dt = 0, mem_addr = 0, mem_wdata = 0;
- rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, busy = 0;
- timeout counter = 0.
REQ-037 After clr rises, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-038 Macro MEM_ACCESS_TIMEOUT_EN enables the WAIT timeout.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without mem_moc. When the count reaches TIMEOUT, the unit drops mem_mov, enters RESP with rsp_fault = 1 and returns rsp_rdata = 0.
- Undefined: no counter exists, and WAIT persists indefinitely until mem_moc.

Verification
REQ-039 Word load at addr 0x10, with mem_moc asserted 2 cycles into WAIT and mem_rdata = 0xDEADBEEF -> rsp_valid pulse with rsp_rdata = 0xDEADBEEF, rsp_fault = 0, mem_rw = 1 throughout.
REQ-040 Signed byte load, mem_rdata = 0x00000080 -> rsp_rdata = 0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-041 Halfword store, addr 0x03, wdata 0x12345678 -> rsp_fault = 1 one cycle after acceptance, and mem_mov never asserts.
REQ-042 Halfword store, addr 0x04, wdata 0x12345678 -> mem_wdata = 0x00005678, mem_rw = 0, then rsp_valid = 1 with rsp_rdata = 0.
REQ-043 With MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT = 4 and mem_moc never asserted -> rsp_fault = 1 after 4 WAIT cycles and mem_mov drops; with the macro undefined -> busy stays 1 for 100 cycles.
REQ-044 clr pulled low in WAIT -> mem_mov = 0 immediately, no rsp_valid; after clr rises, the next word load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a control unit and a RAM with MOC handshake; latency 3+ cycles (1 for alignment faults).
// One request at a time (req_ready only in IDLE), no response back-pressure; MEM_ACCESS_TIMEOUT_EN adds a WAIT timeout.
module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_dt,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_dt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_moc,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_write;
    logic              r_signed;
    logic              r_rw;
    logic [1:0]        r_dt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_fault;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0]        r_cnt;
`endif

    logic              w_accept;
    logic              w_bad;
    logic [DATA_W-1:0] w_wmask;
    logic [DATA_W-1:0] w_rmask;
    logic              w_sign;
    logic [DATA_W-1:0] w_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    assign w_bad = (req_dt == 2'b11) ||
                   ((req_dt == 2'b01) && req_addr[0]) ||
                   ((req_dt == 2'b10) && (req_addr[1:0] != 2'b00));

    assign w_wmask = (req_dt == 2'b00) ? DATA_W'(8'hFF) :
                     (req_dt == 2'b01) ? DATA_W'(16'hFFFF) : DATA_W'(32'hFFFF_FFFF);

    assign w_rmask = (r_dt == 2'b00) ? DATA_W'(8'hFF) :
                     (r_dt == 2'b01) ? DATA_W'(16'hFFFF) : DATA_W'(32'hFFFF_FFFF);

    // Sign bit is the MSB of the accessed field; bits above the field take it (or zero).
    assign w_sign = r_signed & ((r_dt == 2'b00) ? mem_rdata[7] :
                                (r_dt == 2'b01) ? mem_rdata[15] : mem_rdata[31]);
    assign w_ext  = (mem_rdata & w_rmask) | ({DATA_W{w_sign}} & ~w_rmask);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_rw     <= 1'b1;
            r_dt     <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            r_cnt    <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_signed <= req_signed;
                        r_rw     <= ~req_write;
                        r_dt     <= req_dt;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata & w_wmask;
                        if (w_bad) begin
                            r_state <= S_RESP;
                            r_fault <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    r_cnt   <= 8'd0;
`endif
                end
                S_WAIT: begin
                    if (mem_moc) begin
                        r_state <= S_RESP;
                        r_fault <= 1'b0;
                        r_rdata <= r_write ? '0 : w_ext;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state <= S_RESP;
                        r_fault <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign mem_mov   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign mem_rw    = r_rw;
    assign mem_dt    = r_dt;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_fault = r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed-vector bench for mem_access_unit; expected responses go to a queue drained by a monitor on rsp_valid.
module tb_mem_access_unit;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [1:0]    req_dt;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          mem_mov, mem_rw, mem_moc;
    logic [1:0]    mem_dt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          rsp_valid, rsp_fault, busy;
    logic [DW-1:0] rsp_rdata;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          fault;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dt(req_dt), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_dt(mem_dt), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_moc(mem_moc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clr && rsp_valid) begin
            rsp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_fault", 64'(rsp_fault), 64'(e.fault));
            end
        end
    end

    task automatic push_exp(input logic [DW-1:0] rd, input logic f);
        rsp_t e;
        e.rdata = rd;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] dt, input logic sgn,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_write  = wr;
        req_dt     = dt;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    // dly < 0: fault expected at acceptance; otherwise mem_moc comes dly cycles into WAIT.
    task automatic do_req(input logic wr, input logic [1:0] dt, input logic sgn,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int dly, input bit moc_in_issue,
                          input logic [DW-1:0] exp_rd, input logic exp_f,
                          input logic [DW-1:0] exp_wd);
        wait_ready();
        push_exp(exp_rd, exp_f);
        drive_req(wr, dt, sgn, addr, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (dly < 0) begin
            @(negedge clk);
            check("fault_latency", 64'(rsp_valid), 64'd1);
            check("fault_no_mov", 64'(mem_mov), 64'd0);
            return;
        end
        if (moc_in_issue) begin
            mem_moc   = 1'b1;
            mem_rdata = 32'h0000_0001;
        end
        @(negedge clk);
        check("issue_mov_rw", {mem_mov, mem_rw, rsp_valid}, {1'b1, ~wr, 1'b0});
        check("issue_addr", 64'(mem_addr), 64'(addr));
        check("issue_wdata", 64'(mem_wdata), 64'(exp_wd));
        check("issue_dt", 64'(mem_dt), 64'(dt));
        @(posedge clk);
        #1 mem_moc = 1'b0;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            check("wait_hold", {rsp_valid, mem_mov, mem_rw}, {1'b0, 1'b1, ~wr});
            @(posedge clk);
            #1;
        end
        mem_moc   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1 mem_moc = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;
        @(negedge clk);
        check("resp_cycle", {rsp_valid, mem_mov}, 2'b10);
    endtask

    initial begin
        int bad;
        clr = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_dt = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; mem_moc = 1'b0; mem_rdata = '0;
        #12;
        check("rst_mem", {mem_mov, mem_rw, mem_dt}, {1'b0, 1'b1, 2'b00});
        check("rst_addr_wdata", {32'(mem_addr), mem_wdata}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_fault, busy, rsp_rdata}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("rst_ready", 64'(req_ready), 64'd1);

        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'hCAFE_F00D, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hCAFE_F00D);
        do_req(1'b0, 2'b00, 1'b1, 8'h21, 32'h0, 32'h0000_0080, 0, 1'b0, 32'hFFFF_FF80, 1'b0, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 8'h21, 32'h0, 32'h0000_0080, 1, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 8'h03, 32'h1234_5678, 32'h0, -1, 1'b0, 32'h0, 1'b1, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 8'h04, 32'h1234_5678, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_5678);
        do_req(1'b0, 2'b01, 1'b1, 8'h06, 32'h0, 32'h1234_8001, 1, 1'b0, 32'hFFFF_8001, 1'b0, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 8'h02, 32'h0, 32'hFFFF_8001, 0, 1'b0, 32'h0000_8001, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("rdata_hold", 64'(rsp_rdata), 64'h0000_8001);
        do_req(1'b1, 2'b00, 1'b0, 8'h07, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_00DD);
        do_req(1'b0, 2'b10, 1'b0, 8'h02, 32'h0, 32'h0, -1, 1'b0, 32'h0, 1'b1, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 32'h0, -1, 1'b0, 32'h0, 1'b1, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 8'h08, 32'hA5A5_A5A5, 32'h0, 3, 1'b0, 32'h0, 1'b0, 32'hA5A5_A5A5);

        // No mem_moc: load to 0x40, with a second request held on the port while busy.
        wait_ready();
        drive_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h0);
        @(posedge clk);
        #1 req_addr = 8'h80;
`ifdef MEM_ACCESS_TIMEOUT_EN
        push_exp(32'h0, 1'b1);
        @(negedge clk);
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("to_wait", {mem_mov, req_ready, busy}, 3'b101);
            check("to_addr", 64'(mem_addr), 64'h40);
        end
        @(negedge clk);
        check("to_resp", {rsp_valid, mem_mov}, 2'b10);
        req_valid = 1'b0;
        // Bring a fresh load into WAIT so the abort below hits an access in flight.
        wait_ready();
        drive_req(1'b0, 2'b10, 1'b0, 8'h30, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy || !mem_mov || req_ready || mem_addr != 8'h40) bad++;
        end
        check("hang_busy", 64'(bad), 64'd0);
        req_valid = 1'b0;
        @(posedge clk);
`endif
        #2 clr = 1'b0;
        #1;
        check("abort_mov", {mem_mov, busy, rsp_valid, mem_rw}, 4'b0001);
        check("abort_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1 check("abort_ready", 64'(req_ready), 64'd1);
        do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0);

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule
